// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: clears the BTB after reset, predicts next_pc in fetch
// from BTB hit plus 2-bit direction counters, and repairs mispredictions in execute.
module branch_predict_ctrl #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    input  logic             btb_hit_f,
    input  logic [31:0]      btb_target_f,
    input  logic             br_valid_e,
    input  logic             br_taken_e,
    input  logic [31:0]      br_target_e,
    input  logic [31:0]      pc_e,
    input  logic             pred_taken_e,
    input  logic [31:0]      pred_target_e,
    output logic [31:0]      next_pc_f,
    output logic             pred_taken_f,
    output logic             stall_f,
    output logic             flush_fd,
    output logic             btb_we,
    output logic [IDX_W-1:0] btb_idx,
    output logic             btb_wvalid,
    output logic [31:0]      btb_wdata,
    output logic [CNT_W-1:0] misp_count
);

    localparam int ENTRIES = 2 ** IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] sweep_idx;
    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] idx_f, idx_e;
    logic             mispredict;
    logic [31:0]      correct_pc;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign idx_f      = pc_f[IDX_W+1:2];
    assign idx_e      = pc_e[IDX_W+1:2];
    assign correct_pc = br_taken_e ? br_target_e : pc_e + 32'd4;

    always_comb begin
        next_state   = state;
        next_pc_f    = pc_f;
        pred_taken_f = 1'b0;
        stall_f      = 1'b0;
        flush_fd     = 1'b0;
        btb_we       = 1'b0;
        btb_idx      = '0;
        btb_wvalid   = 1'b0;
        btb_wdata    = '0;
        mispredict   = 1'b0;
        if (reset) begin
            // Outputs must be quiet as soon as reset rises, before the state register reacts.
            stall_f = 1'b1;
        end else begin
            case (state)
                INIT: begin
                    stall_f = 1'b1;
                    btb_we  = 1'b1;
                    btb_idx = sweep_idx;
                    if (sweep_idx == {IDX_W{1'b1}})
                        next_state = RUN;
                end
                RUN: begin
                    pred_taken_f = btb_hit_f & ctr[idx_f][1];
                    next_pc_f    = pred_taken_f ? btb_target_f : pc_f + 32'd4;
                    if (br_valid_e) begin
                        mispredict = (br_taken_e != pred_taken_e) |
                                     (br_taken_e & pred_taken_e & (br_target_e != pred_target_e));
                        if (br_taken_e) begin
                            btb_we     = 1'b1;
                            btb_idx    = idx_e;
                            btb_wvalid = 1'b1;
                            btb_wdata  = br_target_e;
                        end else if (ctr[idx_e] == 2'b00) begin
                            btb_we  = 1'b1;
                            btb_idx = idx_e;
                        end
                    end
                    // A resolved mispredict outranks whatever fetch guessed this cycle.
                    if (mispredict) begin
                        next_pc_f    = correct_pc;
                        pred_taken_f = 1'b0;
                        flush_fd     = 1'b1;
                    end
                end
                default: next_state = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            sweep_idx  <= '0;
            misp_count <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= 2'b01;
        end else begin
            state <= next_state;
            if (state == INIT)
                sweep_idx <= sweep_idx + 1'b1;
            if (state == RUN && br_valid_e)
                ctr[idx_e] <= br_taken_e ? sat_inc2(ctr[idx_e]) : sat_dec2(ctr[idx_e]);
            if (mispredict)
                misp_count <= sat_inc_cnt(misp_count);
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: reset sweep, fetch/resolve vector table,
// reset during RUN and mispredict counter saturation.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f, btb_target_f, br_target_e, pc_e, pred_target_e;
    logic        btb_hit_f, br_valid_e, br_taken_e, pred_taken_e;
    logic [31:0] next_pc_f;
    logic        pred_taken_f, stall_f, flush_fd, btb_we, btb_wvalid;
    logic [3:0]  btb_idx;
    logic [31:0] btb_wdata;
    logic [15:0] misp_count;

    int checks = 0;
    int failures = 0;

    branch_predict_ctrl #(.IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .btb_hit_f(btb_hit_f),
        .btb_target_f(btb_target_f), .br_valid_e(br_valid_e), .br_taken_e(br_taken_e),
        .br_target_e(br_target_e), .pc_e(pc_e), .pred_taken_e(pred_taken_e),
        .pred_target_e(pred_target_e), .next_pc_f(next_pc_f), .pred_taken_f(pred_taken_f),
        .stall_f(stall_f), .flush_fd(flush_fd), .btb_we(btb_we), .btb_idx(btb_idx),
        .btb_wvalid(btb_wvalid), .btb_wdata(btb_wdata), .misp_count(misp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_f;
        logic        hit;
        logic [31:0] tgt_f;
        logic        bv;
        logic        bt;
        logic [31:0] br_tgt;
        logic [31:0] pc_e;
        logic        pte;
        logic [31:0] ptg;
        logic [31:0] e_next;
        logic        e_pred;
        logic        e_flush;
        logic        e_we;
        logic [3:0]  e_idx;
        logic        e_wv;
        logic [31:0] e_wd;
        logic [15:0] e_misp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_br(input logic bv, input logic bt, input logic [31:0] tgt,
                          input logic [31:0] pce, input logic pte, input logic [31:0] ptg);
        br_valid_e = bv; br_taken_e = bt; br_target_e = tgt;
        pc_e = pce; pred_taken_e = pte; pred_target_e = ptg;
    endtask

    // Called at a negedge after reset release; returns at the negedge after 16 rising edges.
    task automatic do_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("%s_we%0d", tag, i), {31'd0, btb_we}, 32'd1);
            chk($sformatf("%s_idx%0d", tag, i), {28'd0, btb_idx}, i);
            chk($sformatf("%s_wv%0d", tag, i), {31'd0, btb_wvalid}, 32'd0);
            chk($sformatf("%s_stall%0d", tag, i), {31'd0, stall_f}, 32'd1);
            chk($sformatf("%s_flush%0d", tag, i), {31'd0, flush_fd}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        //            pc_f          hit tgt_f     bv bt br_tgt  pc_e         pte ptg      next        pr fl we idx wv wd       misp
        vecs[0]  = '{32'h40,        0, 32'h0,    0, 0, 32'h0,   32'h0,       0, 32'h0,   32'h44,     0, 0, 0, 0, 0, 32'h0,   16'd0};
        vecs[1]  = '{32'h40,        0, 32'h0,    1, 1, 32'h80,  32'h40,      0, 32'h44,  32'h80,     0, 1, 1, 0, 1, 32'h80,  16'd1};
        vecs[2]  = '{32'h40,        1, 32'h80,   1, 1, 32'h80,  32'h40,      1, 32'h80,  32'h80,     1, 0, 1, 0, 1, 32'h80,  16'd1};
        vecs[3]  = '{32'h40,        1, 32'h80,   1, 1, 32'h80,  32'h40,      1, 32'h80,  32'h80,     1, 0, 1, 0, 1, 32'h80,  16'd1};
        vecs[4]  = '{32'h200,       0, 32'h0,    1, 0, 32'h80,  32'h40,      1, 32'h80,  32'h44,     0, 1, 0, 0, 0, 32'h0,   16'd2};
        vecs[5]  = '{32'h200,       0, 32'h0,    1, 0, 32'h80,  32'h40,      1, 32'h80,  32'h44,     0, 1, 0, 0, 0, 32'h0,   16'd3};
        vecs[6]  = '{32'h200,       0, 32'h0,    1, 0, 32'h80,  32'h40,      1, 32'h80,  32'h44,     0, 1, 0, 0, 0, 32'h0,   16'd4};
        vecs[7]  = '{32'h200,       0, 32'h0,    1, 0, 32'h80,  32'h40,      0, 32'h44,  32'h204,    0, 0, 1, 0, 0, 32'h0,   16'd4};
        vecs[8]  = '{32'h40,        1, 32'h80,   0, 0, 32'h0,   32'h0,       0, 32'h0,   32'h44,     0, 0, 0, 0, 0, 32'h0,   16'd4};
        vecs[9]  = '{32'h300,       0, 32'h0,    1, 1, 32'h120, 32'h48,      1, 32'h100, 32'h120,    0, 1, 1, 2, 1, 32'h120, 16'd5};
        vecs[10] = '{32'h48,        1, 32'h120,  1, 1, 32'h120, 32'h48,      1, 32'h120, 32'h120,    1, 0, 1, 2, 1, 32'h120, 16'd5};
        vecs[11] = '{32'h48,        1, 32'h120,  1, 0, 32'h120, 32'h48,      0, 32'h4C,  32'h120,    1, 0, 0, 0, 0, 32'h0,   16'd5};
        vecs[12] = '{32'h48,        1, 32'h120,  0, 0, 32'h0,   32'h0,       0, 32'h0,   32'h120,    1, 0, 0, 0, 0, 32'h0,   16'd5};
        vecs[13] = '{32'h48,        1, 32'h120,  1, 0, 32'h120, 32'h48,      0, 32'h4C,  32'h120,    1, 0, 0, 0, 0, 32'h0,   16'd5};
        vecs[14] = '{32'h48,        1, 32'h120,  0, 0, 32'h0,   32'h0,       0, 32'h0,   32'h4C,     0, 0, 0, 0, 0, 32'h0,   16'd5};
        vecs[15] = '{32'hFFFFFFFC,  0, 32'h0,    1, 0, 32'h8,   32'hFFFFFFFC, 1, 32'h8,  32'h0,      0, 1, 0, 0, 0, 32'h0,   16'd6};

        reset = 1'b1;
        pc_f = 32'h40; btb_hit_f = 1'b0; btb_target_f = 32'h0;
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", {31'd0, btb_we}, 32'd0);
        chk("rst_stall", {31'd0, stall_f}, 32'd1);
        chk("rst_flush", {31'd0, flush_fd}, 32'd0);
        chk("rst_pred", {31'd0, pred_taken_f}, 32'd0);
        chk("rst_next", next_pc_f, 32'h40);
        chk("rst_misp", {16'd0, misp_count}, 32'd0);

        // Sweep with a mispredicting branch presented; it must be ignored.
        @(negedge clk);
        reset = 1'b0;
        set_br(1'b1, 1'b1, 32'h80, 32'h40, 1'b0, 32'h44);
        do_sweep("sweep");
        set_br(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("run_stall", {31'd0, stall_f}, 32'd0);
        chk("run_misp", {16'd0, misp_count}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            pc_f = vecs[i].pc_f; btb_hit_f = vecs[i].hit; btb_target_f = vecs[i].tgt_f;
            set_br(vecs[i].bv, vecs[i].bt, vecs[i].br_tgt, vecs[i].pc_e, vecs[i].pte, vecs[i].ptg);
            #1;
            chk($sformatf("v%0d_next", i), next_pc_f, vecs[i].e_next);
            chk($sformatf("v%0d_pred", i), {31'd0, pred_taken_f}, {31'd0, vecs[i].e_pred});
            chk($sformatf("v%0d_flush", i), {31'd0, flush_fd}, {31'd0, vecs[i].e_flush});
            chk($sformatf("v%0d_we", i), {31'd0, btb_we}, {31'd0, vecs[i].e_we});
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_idx", i), {28'd0, btb_idx}, {28'd0, vecs[i].e_idx});
                chk($sformatf("v%0d_wv", i), {31'd0, btb_wvalid}, {31'd0, vecs[i].e_wv});
                chk($sformatf("v%0d_wd", i), btb_wdata, vecs[i].e_wd);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_misp", i), {16'd0, misp_count}, {16'd0, vecs[i].e_misp});
            @(negedge clk);
        end

        // Reset in RUN while a mispredicting branch resolves.
        pc_f = 32'h48; btb_hit_f = 1'b1; btb_target_f = 32'h120;
        set_br(1'b1, 1'b1, 32'h80, 32'h40, 1'b0, 32'h44);
        #1;
        chk("pre_rst_flush", {31'd0, flush_fd}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", {31'd0, btb_we}, 32'd0);
        chk("mid_rst_flush", {31'd0, flush_fd}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_f}, 32'd1);
        chk("mid_rst_misp", {16'd0, misp_count}, 32'd0);
        chk("mid_rst_next", next_pc_f, 32'h48);
        @(negedge clk);
        reset = 1'b0;
        do_sweep("resweep");
        #1;
        chk("post_rst_ctr", {31'd0, pred_taken_f}, 32'd0);
        chk("post_rst_flush", {31'd0, flush_fd}, 32'd1);

        // Mispredict every cycle: counter must stop at all-ones.
        repeat (65535) @(posedge clk);
        #1;
        chk("misp_ffff", {16'd0, misp_count}, 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("misp_sat", {16'd0, misp_count}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
